// File: rtl/fft_input_loader.sv
// Serial-to-parallel frame loader for the 32-point FFT front end.
// Samples fill two ping-pong banks; a completed bank is presented as 32 parallel words.
module fft_input_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int INTEGER    = 4,
    parameter int FRACTION   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out0_real,
    output logic [DATA_WIDTH-1:0] out1_real,
    output logic [DATA_WIDTH-1:0] out2_real,
    output logic [DATA_WIDTH-1:0] out3_real,
    output logic [DATA_WIDTH-1:0] out4_real,
    output logic [DATA_WIDTH-1:0] out5_real,
    output logic [DATA_WIDTH-1:0] out6_real,
    output logic [DATA_WIDTH-1:0] out7_real,
    output logic [DATA_WIDTH-1:0] out8_real,
    output logic [DATA_WIDTH-1:0] out9_real,
    output logic [DATA_WIDTH-1:0] out10_real,
    output logic [DATA_WIDTH-1:0] out11_real,
    output logic [DATA_WIDTH-1:0] out12_real,
    output logic [DATA_WIDTH-1:0] out13_real,
    output logic [DATA_WIDTH-1:0] out14_real,
    output logic [DATA_WIDTH-1:0] out15_real,
    output logic [DATA_WIDTH-1:0] out16_real,
    output logic [DATA_WIDTH-1:0] out17_real,
    output logic [DATA_WIDTH-1:0] out18_real,
    output logic [DATA_WIDTH-1:0] out19_real,
    output logic [DATA_WIDTH-1:0] out20_real,
    output logic [DATA_WIDTH-1:0] out21_real,
    output logic [DATA_WIDTH-1:0] out22_real,
    output logic [DATA_WIDTH-1:0] out23_real,
    output logic [DATA_WIDTH-1:0] out24_real,
    output logic [DATA_WIDTH-1:0] out25_real,
    output logic [DATA_WIDTH-1:0] out26_real,
    output logic [DATA_WIDTH-1:0] out27_real,
    output logic [DATA_WIDTH-1:0] out28_real,
    output logic [DATA_WIDTH-1:0] out29_real,
    output logic [DATA_WIDTH-1:0] out30_real,
    output logic [DATA_WIDTH-1:0] out31_real,
    output logic                  frame_err
);

    localparam int N = 32;

    // Q-format bookkeeping only; an empty marker block flags an inconsistent format in the hierarchy.
    if (INTEGER + FRACTION > DATA_WIDTH) begin : g_qformat_wider_than_word
    end

    logic [DATA_WIDTH-1:0] bank_reg [2][N];
    logic [4:0]            wr_idx_reg, wr_idx_next;
    logic                  wr_bank_reg, wr_bank_next;
    logic                  rd_bank_reg, rd_bank_next;
    logic [1:0]            full_reg, full_next;
    logic                  frame_err_reg, frame_err_next;
    logic                  accept, store, drain;
    logic [DATA_WIDTH-1:0] frame_out [N];

    assign in_ready  = reset & ~full_reg[wr_bank_reg];
    assign out_valid = full_reg[rd_bank_reg];
    assign frame_err = frame_err_reg;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;
    // An early in_last sample is dropped together with the partial frame.
    assign store     = accept & ((wr_idx_reg == 5'd31) | ~in_last);

    always_comb begin
        wr_idx_next    = wr_idx_reg;
        wr_bank_next   = wr_bank_reg;
        rd_bank_next   = rd_bank_reg;
        full_next      = full_reg;
        frame_err_next = 1'b0;
        if (accept) begin
            if (wr_idx_reg == 5'd31) begin
                wr_idx_next             = 5'd0;
                full_next[wr_bank_reg]  = 1'b1;
                wr_bank_next            = ~wr_bank_reg;
                frame_err_next          = ~in_last;
            end else if (in_last) begin
                wr_idx_next    = 5'd0;
                frame_err_next = 1'b1;
            end else begin
                wr_idx_next = wr_idx_reg + 5'd1;
            end
        end
        // The drained bank is never the one being filled, so both updates can land together.
        if (drain) begin
            full_next[rd_bank_reg] = 1'b0;
            rd_bank_next           = ~rd_bank_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_idx_reg    <= 5'd0;
            wr_bank_reg   <= 1'b0;
            rd_bank_reg   <= 1'b0;
            full_reg      <= 2'b00;
            frame_err_reg <= 1'b0;
        end else begin
            wr_idx_reg    <= wr_idx_next;
            wr_bank_reg   <= wr_bank_next;
            rd_bank_reg   <= rd_bank_next;
            full_reg      <= full_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Bank storage is not reset; stale contents are hidden behind out_valid.
    always_ff @(posedge clk) begin
        if (store) begin
            bank_reg[wr_bank_reg][wr_idx_reg] <= in_data;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_frame_out
        assign frame_out[gi] = out_valid ? bank_reg[rd_bank_reg][gi] : '0;
    end

    assign out0_real  = frame_out[0];
    assign out1_real  = frame_out[1];
    assign out2_real  = frame_out[2];
    assign out3_real  = frame_out[3];
    assign out4_real  = frame_out[4];
    assign out5_real  = frame_out[5];
    assign out6_real  = frame_out[6];
    assign out7_real  = frame_out[7];
    assign out8_real  = frame_out[8];
    assign out9_real  = frame_out[9];
    assign out10_real = frame_out[10];
    assign out11_real = frame_out[11];
    assign out12_real = frame_out[12];
    assign out13_real = frame_out[13];
    assign out14_real = frame_out[14];
    assign out15_real = frame_out[15];
    assign out16_real = frame_out[16];
    assign out17_real = frame_out[17];
    assign out18_real = frame_out[18];
    assign out19_real = frame_out[19];
    assign out20_real = frame_out[20];
    assign out21_real = frame_out[21];
    assign out22_real = frame_out[22];
    assign out23_real = frame_out[23];
    assign out24_real = frame_out[24];
    assign out25_real = frame_out[25];
    assign out26_real = frame_out[26];
    assign out27_real = frame_out[27];
    assign out28_real = frame_out[28];
    assign out29_real = frame_out[29];
    assign out30_real = frame_out[30];
    assign out31_real = frame_out[31];

endmodule

// File: tb/tb_fft_input_loader.sv
// Scoreboard bench for fft_input_loader: the driver models framing and queues
// expected frames, the monitor pops and compares them on each frame handshake.
module tb_fft_input_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic         frame_err;
    wire  [255:0] obs;

    int total = 0;
    int bad = 0;
    int model_idx = 0;
    int err_exp = 0;
    int err_seen = 0;
    int stall_cnt = 0;
    int valid_cycles = 0;
    logic [255:0] cur_frame = '0;
    logic [255:0] exp_q[$];

    always #5 clk = ~clk;

    fft_input_loader #(.DATA_WIDTH(8), .INTEGER(4), .FRACTION(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0_real(obs[7:0]),      .out1_real(obs[15:8]),     .out2_real(obs[23:16]),
        .out3_real(obs[31:24]),    .out4_real(obs[39:32]),    .out5_real(obs[47:40]),
        .out6_real(obs[55:48]),    .out7_real(obs[63:56]),    .out8_real(obs[71:64]),
        .out9_real(obs[79:72]),    .out10_real(obs[87:80]),   .out11_real(obs[95:88]),
        .out12_real(obs[103:96]),  .out13_real(obs[111:104]), .out14_real(obs[119:112]),
        .out15_real(obs[127:120]), .out16_real(obs[135:128]), .out17_real(obs[143:136]),
        .out18_real(obs[151:144]), .out19_real(obs[159:152]), .out20_real(obs[167:160]),
        .out21_real(obs[175:168]), .out22_real(obs[183:176]), .out23_real(obs[191:184]),
        .out24_real(obs[199:192]), .out25_real(obs[207:200]), .out26_real(obs[215:208]),
        .out27_real(obs[223:216]), .out28_real(obs[231:224]), .out29_real(obs[239:232]),
        .out30_real(obs[247:240]), .out31_real(obs[255:248]),
        .frame_err(frame_err)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Presents one sample, waits (bounded) for in_ready, and updates the framing model on accept.
    task automatic send(input logic [7:0] d, input logic last);
        int w = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            chk("send_timeout", 256'd0, 256'd1);
            in_valid = 1'b0;
            return;
        end
        stall_cnt += w;
        @(posedge clk); #1;
        if (model_idx == 31) begin
            cur_frame[31*8 +: 8] = d;
            exp_q.push_back(cur_frame);
            if (!last) err_exp++;
            model_idx = 0;
        end else if (last) begin
            model_idx = 0;
            err_exp++;
        end else begin
            cur_frame[model_idx*8 +: 8] = d;
            model_idx++;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] base, input logic with_last);
        for (int i = 0; i < 32; i++) send(base + 8'(i), with_last && (i == 31));
    endtask

    always @(negedge clk) begin
        if (frame_err) err_seen++;
        if (out_valid) valid_cycles++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", obs, 256'd0);
            end else begin
                chk("frame_data", obs, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 256'(in_ready), 256'd0);
        chk("rst_out_valid", 256'(out_valid), 256'd0);
        chk("rst_frame_err", 256'(frame_err), 256'd0);
        chk("rst_outputs", obs, 256'd0);
        reset = 1'b1;
        #1;
        chk("rel_in_ready", 256'(in_ready), 256'd1);

        // Single frame, held by out_ready=0
        send_frame(8'h00, 1'b1);
        chk("single_latency", 256'(out_valid), 256'd1);
        chk("single_in_ready", 256'(in_ready), 256'd1);
        chk("single_data", obs, 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100);
        idle(3);
        chk("single_hold", 256'(out_valid), 256'd1);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        chk("single_drained", 256'(out_valid), 256'd0);
        chk("single_zero_out", obs, 256'd0);

        // Backpressure: two frames fill both banks
        stall_cnt = 0;
        send_frame(8'h20, 1'b1);
        send_frame(8'h40, 1'b1);
        chk("bp_no_stall", 256'(stall_cnt), 256'd0);
        chk("bp_ready_low", 256'(in_ready), 256'd0);
        idle(2);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        chk("bp_ready_back", 256'(in_ready), 256'd1);
        chk("bp_next_valid", 256'(out_valid), 256'd1);
        chk("bp_next_data", obs, (exp_q.size() > 0) ? exp_q[0] : 256'd0);
        send_frame(8'h60, 1'b1);
        chk("bp_full_again", 256'(in_ready), 256'd0);
        out_ready = 1'b1;
        idle(4);
        chk("bp_drained", 256'(exp_q.size()), 256'd0);

        // Continuous streaming at full rate
        stall_cnt = 0;
        valid_cycles = 0;
        for (int f = 0; f < 10; f++) send_frame(8'(f * 32), 1'b1);
        idle(3);
        chk("stream_no_stall", 256'(stall_cnt), 256'd0);
        chk("stream_valid_cycles", 256'(valid_cycles), 256'd10);
        chk("stream_drained", 256'(exp_q.size()), 256'd0);
        chk("stream_err", 256'(err_seen), 256'(err_exp));

        // Early in_last on sample 10, then a clean frame
        for (int i = 0; i <= 10; i++) send(8'h80 + 8'(i), i == 10);
        idle(2);
        chk("early_no_frame", 256'(out_valid), 256'd0);
        chk("early_err_once", 256'(err_seen), 256'(err_exp));
        send_frame(8'hA0, 1'b1);
        idle(3);
        chk("early_recovered", 256'(exp_q.size()), 256'd0);

        // Missing in_last
        send_frame(8'hC5, 1'b0);
        idle(3);
        chk("missing_err", 256'(err_seen), 256'(err_exp));
        chk("missing_drained", 256'(exp_q.size()), 256'd0);

        // Reset with one frame pending and 20 samples into the next
        out_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        for (int i = 0; i < 20; i++) send(8'hE0 + 8'(i), 1'b0);
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        model_idx = 0;
        cur_frame = '0;
        #1;
        chk("mid_rst_valid", 256'(out_valid), 256'd0);
        chk("mid_rst_outputs", obs, 256'd0);
        chk("mid_rst_ready", 256'(in_ready), 256'd1);
        send_frame(8'h33, 1'b1);
        chk("mid_rst_frame_valid", 256'(out_valid), 256'd1);
        out_ready = 1'b1;
        idle(3);
        chk("mid_rst_drained", 256'(exp_q.size()), 256'd0);
        chk("final_err", 256'(err_seen), 256'(err_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
